dff_chain_loader: RTL and testbench
===================================

Name: dff_chain_loader

Overview:
Controller that sequences loading of an external chain of WIDTH d_flip_flop cells.
- Accepts a parallel word over a valid/ready handshake.
- Serialises the word onto the chain's D input, one bit per clock, with a per-bit enable.
- Pulses a latch strobe when the word is complete.
- Also drives the chain's clear line on request.
- Sits between the register-programming logic and the flip-flop bank, so no requester ever toggles the chain directly.

Parameters:
- WIDTH, 8, number of flip-flops in the chain and bits per word (>=2).
- MSB_FIRST, 1, 1 = shift in_data[WIDTH-1] first; 0 = in_data[0] first.

Ports:
- clock, input, 1, single rising-edge clock.
- reset, input, 1, asynchronous active-low reset.
- in_valid, input, 1, requester has a word.
- in_ready, output, 1, loader can accept a word this cycle.
- in_data, input, WIDTH, word to load; sampled on the handshake.
- clear_req, input, 1, single-cycle request to clear the chain.
- chain_d, output, 1, serial data to the chain D input.
- chain_en, output, 1, shift enable for the chain; 1 = chain captures chain_d this cycle.
- chain_clr, output, 1, clear to the chain (active-high).
- latch_strobe, output, 1, one-cycle pulse: chain holds the complete word.
- busy, output, 1, high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; shadow register=0; bit counter=0; clear-pending flag=0.
  - chain_d, chain_en, chain_clr, latch_strobe and busy are all 0.
  - in_ready is 0 while reset is asserted.
- States: IDLE, SHIFT, LATCH, CLEAR. All outputs except in_ready are registered.
- in_ready is combinational: (state==IDLE) && !clear_req && !pending && reset.
- IDLE:
  - clear_req=1 or pending=1 -> CLEAR. Clear takes priority over a simultaneous in_valid; the word is not accepted.
  - Otherwise, in_valid && in_ready -> capture in_data into the shadow register, counter=0, go to SHIFT.
- SHIFT:
  - chain_en=1 for exactly WIDTH consecutive cycles.
  - chain_d = shadow bit selected by counter: index WIDTH-1-counter if MSB_FIRST, else counter.
  - Counter increments each cycle; when it reaches WIDTH-1, go to LATCH.
  - Counter width is $clog2(WIDTH); no wrap occurs because the exit is at WIDTH-1.
- LATCH: latch_strobe=1, chain_en=0 for one cycle, then -> IDLE (or -> CLEAR if pending).
- CLEAR: chain_clr=1 for one cycle; pending cleared; then -> IDLE.
- clear_req while busy is not dropped. It sets pending, which is served immediately after LATCH. Multiple requests while busy collapse into one clear.
- Changes to in_data after the handshake have no effect; the shadow register holds the word.
- Latency:
  - Handshake at edge 0.
  - chain_en high on cycles 1..WIDTH.
  - latch_strobe on cycle WIDTH+1.
  - in_ready high again on cycle WIDTH+2 if nothing is pending.
  - Minimum throughput: one word per WIDTH+2 cycles.
- Reset mid-SHIFT: outputs go to 0 immediately. The partially shifted word is abandoned with no latch_strobe. The pending clear is discarded.
- chain_clr and chain_en are never high in the same cycle. latch_strobe never coincides with chain_en.

Decomposition:
- Package dff_chain_pkg holds:
  - a typedef enum logic [1:0] for the states {IDLE, SHIFT, LATCH, CLEAR};
  - a function giving the counter width, $clog2(WIDTH).
- One sub-module, bit_counter: parameterised up-counter with synchronous clear and an at_max flag. It is instantiated once for the SHIFT index.
- FSM, shadow register and pending flag stay in the top module.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release -> all outputs 0 during reset; in_ready=1 and busy=0 on the first cycle after release.
- Basic load, WIDTH=8, MSB_FIRST=1, in_data=8'hA5 -> chain_en=1 for 8 cycles with chain_d = 1,0,1,0,0,1,0,1. latch_strobe=1 on cycle 9 only; in_ready=1 on cycle 10. A bench chain of 8 d_flip_flop cells reads 8'hA5.
- LSB first, MSB_FIRST=0, in_data=8'h01 -> chain_d = 1,0,0,0,0,0,0,0. Changing in_data to 8'hFF on cycle 2 does not alter the sequence.
- Clear priority: clear_req=1 and in_valid=1 in the same IDLE cycle -> in_ready=0, no handshake, chain_clr=1 next cycle. The word is accepted on the cycle after CLEAR.
- Deferred clear: pulse clear_req twice during SHIFT -> no chain_clr during SHIFT. latch_strobe, then exactly one chain_clr cycle, then IDLE.
- Reset mid-operation: assert reset on SHIFT cycle 4 -> chain_en, chain_d and busy drop to 0 asynchronously. No latch_strobe or chain_clr follows. in_ready=1 after release.

Source files
------------

// File: rtl/dff_chain_pkg.sv
// Shared types for the flip-flop chain loader: FSM state encoding and
// the width of the bit-index counter.
package dff_chain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2,
        CLEAR = 2'd3
    } state_t;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/bit_counter.sv
// Up-counter with synchronous clear and a flag raised when the count
// equals MAX.
module bit_counter #(
    parameter int W   = 3,
    parameter int MAX = 7
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         at_max
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

    assign at_max = (count == W'(MAX));

endmodule

// File: rtl/dff_chain_loader.sv
// Loads a parallel word into an external chain of WIDTH flip-flops one
// bit per clock, strobes a latch when done and serves chain clears.
//
//   state | meaning
//   IDLE  | waiting for a word or a clear request
//   SHIFT | chain_en high, one bit of the shadow word per cycle
//   LATCH | latch_strobe high, chain holds the complete word
//   CLEAR | chain_clr high for one cycle
module dff_chain_loader
    import dff_chain_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clear_req,
    output logic             chain_d,
    output logic             chain_en,
    output logic             chain_clr,
    output logic             latch_strobe,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shadow, shadow_nxt;
    logic             pending, pending_nxt;
    logic             d_nxt, en_nxt, clr_nxt, strobe_nxt, busy_nxt;
    logic             cnt_clr, cnt_inc;
    logic [CW-1:0]    count;
    logic             at_max;

    function automatic logic pick(input logic [WIDTH-1:0] w, input logic [CW-1:0] i);
        logic [CW-1:0] j;
        j = MSB_FIRST ? (CW'(WIDTH - 1) - i) : i;
        return w[j];
    endfunction

    bit_counter #(
        .W   (CW),
        .MAX (WIDTH - 1)
    ) u_bit_counter (
        .clock  (clock),
        .reset  (reset),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .count  (count),
        .at_max (at_max)
    );

    assign in_ready = (state == IDLE) && !clear_req && !pending && reset;

    // Outputs are computed for the next state so they can be registered
    // without adding a cycle of latency.
    always_comb begin
        state_nxt   = state;
        shadow_nxt  = shadow;
        pending_nxt = pending;
        d_nxt       = 1'b0;
        en_nxt      = 1'b0;
        clr_nxt     = 1'b0;
        strobe_nxt  = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        case (state)
            IDLE: begin
                if (clear_req || pending) begin
                    state_nxt   = CLEAR;
                    clr_nxt     = 1'b1;
                    pending_nxt = 1'b0;
                end else if (in_valid && in_ready) begin
                    state_nxt  = SHIFT;
                    shadow_nxt = in_data;
                    cnt_clr    = 1'b1;
                    en_nxt     = 1'b1;
                    d_nxt      = pick(in_data, '0);
                end
            end
            SHIFT: begin
                if (clear_req) begin
                    pending_nxt = 1'b1;
                end
                if (at_max) begin
                    state_nxt  = LATCH;
                    strobe_nxt = 1'b1;
                    cnt_clr    = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                    en_nxt  = 1'b1;
                    d_nxt   = pick(shadow, count + CW'(1));
                end
            end
            LATCH: begin
                // A clear arriving while one is already pending collapses into it.
                if (pending) begin
                    state_nxt   = CLEAR;
                    clr_nxt     = 1'b1;
                    pending_nxt = 1'b0;
                end else begin
                    state_nxt   = IDLE;
                    pending_nxt = clear_req;
                end
            end
            CLEAR: begin
                state_nxt   = IDLE;
                pending_nxt = clear_req;
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            shadow       <= '0;
            pending      <= 1'b0;
            chain_d      <= 1'b0;
            chain_en     <= 1'b0;
            chain_clr    <= 1'b0;
            latch_strobe <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            shadow       <= shadow_nxt;
            pending      <= pending_nxt;
            chain_d      <= d_nxt;
            chain_en     <= en_nxt;
            chain_clr    <= clr_nxt;
            latch_strobe <= strobe_nxt;
            busy         <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_dff_chain_loader.sv
// Bench for dff_chain_loader: an MSB-first and an LSB-first instance share
// stimulus and are checked against a transaction-level schedule model.
module tb_dff_chain_loader;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       clear_req = 1'b0;

    logic rdy_m, d_m, en_m, clr_m, stb_m, busy_m;
    logic rdy_l, d_l, en_l, clr_l, stb_l, busy_l;
    logic [5:0] obs_m, obs_l;
    logic [7:0] chain_m = 8'h00;
    logic [7:0] chain_l = 8'h00;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    dff_chain_loader #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy_m),
        .in_data(in_data), .clear_req(clear_req), .chain_d(d_m), .chain_en(en_m),
        .chain_clr(clr_m), .latch_strobe(stb_m), .busy(busy_m)
    );

    dff_chain_loader #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy_l),
        .in_data(in_data), .clear_req(clear_req), .chain_d(d_l), .chain_en(en_l),
        .chain_clr(clr_l), .latch_strobe(stb_l), .busy(busy_l)
    );

    assign obs_m = {rdy_m, busy_m, en_m, d_m, stb_m, clr_m};
    assign obs_l = {rdy_l, busy_l, en_l, d_l, stb_l, clr_l};

    // Bench flip-flop chains; the first bit shifted ends at the far end.
    always @(posedge clock) begin
        if (clr_m) chain_m <= 8'h00;
        else if (en_m) chain_m <= {chain_m[6:0], d_m};
        if (clr_l) chain_l <= 8'h00;
        else if (en_l) chain_l <= {d_l, chain_l[7:1]};
    end

    // Reference model: a queue of expected per-cycle outputs.
    typedef struct packed {
        logic       en;
        logic       dm;
        logic       dl;
        logic       strobe;
        logic       clr;
        logic [7:0] word;
    } ev_t;

    ev_t cur = '0;
    ev_t q[$];
    bit  m_pending = 1'b0;
    bit  exp_ready = 1'b0;

    task automatic model_reset();
        q.delete();
        cur = '0;
        m_pending = 1'b0;
    endtask

    task automatic model_eval();
        bit  busy_now;
        ev_t e;
        busy_now  = cur.en | cur.strobe | cur.clr;
        exp_ready = !busy_now && !clear_req && !m_pending;
        if (!busy_now) begin
            if (clear_req || m_pending) begin
                e = '0; e.clr = 1'b1; q.push_back(e);
                m_pending = 1'b0;
            end else if (in_valid) begin
                for (int k = 0; k < 8; k++) begin
                    e = '0; e.en = 1'b1;
                    e.dm = in_data[7-k];
                    e.dl = in_data[k];
                    q.push_back(e);
                end
                e = '0; e.strobe = 1'b1; e.word = in_data; q.push_back(e);
            end
        end else if (cur.strobe && m_pending) begin
            e = '0; e.clr = 1'b1; q.push_back(e);
            m_pending = 1'b0;
        end else if (clear_req) begin
            m_pending = 1'b1;
        end
    endtask

    function automatic logic [5:0] exp_vec(input bit lsb);
        return {exp_ready, cur.en | cur.strobe | cur.clr, cur.en,
                lsb ? cur.dl : cur.dm, cur.strobe, cur.clr};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
        cur = (q.size() > 0) ? q.pop_front() : '0;
    endtask

    task automatic test_reset();
        in_valid = 1'b1; in_data = 8'h3C; clear_req = 1'b0; reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            total++;
            if ({obs_m, obs_l} !== 12'b0) begin
                bad++; $display("FAIL reset_hold c=%0d got=%b exp=0", c, {obs_m, obs_l});
            end
        end
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        total++;
        if ({rdy_m, busy_m, rdy_l, busy_l} !== 4'b1010) begin
            bad++; $display("FAIL reset_release got=%b exp=1010", {rdy_m, busy_m, rdy_l, busy_l});
        end
        model_reset();
    endtask

    task automatic test_basic_load();
        int en_cnt, stb_at;
        en_cnt = 0; stb_at = -1;
        for (int c = 0; c < 12; c++) begin
            in_valid = (c == 0); in_data = 8'hA5; clear_req = 1'b0;
            model_eval(); #1;
            total++;
            if (obs_m !== exp_vec(1'b0)) begin bad++; $display("FAIL basic_msb c=%0d got=%b exp=%b", c, obs_m, exp_vec(1'b0)); end
            total++;
            if (obs_l !== exp_vec(1'b1)) begin bad++; $display("FAIL basic_lsb c=%0d got=%b exp=%b", c, obs_l, exp_vec(1'b1)); end
            if (cur.strobe) begin
                total++;
                if (chain_m !== cur.word || chain_l !== cur.word) begin
                    bad++; $display("FAIL basic_chain got=%h/%h exp=%h", chain_m, chain_l, cur.word);
                end
            end
            if (en_m) en_cnt++;
            if (stb_m) stb_at = c;
            tick();
        end
        total++;
        if (en_cnt != 8 || stb_at != 9) begin
            bad++; $display("FAIL basic_timing en_cycles=%0d strobe_at=%0d exp=8/9", en_cnt, stb_at);
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] seq_m, seq_l;
        int k;
        seq_m = 8'h00; seq_l = 8'h00; k = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid = (c == 0); in_data = (c < 2) ? 8'h01 : 8'hFF; clear_req = 1'b0;
            model_eval(); #1;
            total++;
            if (obs_m !== exp_vec(1'b0)) begin bad++; $display("FAIL lsb_msbdut c=%0d got=%b exp=%b", c, obs_m, exp_vec(1'b0)); end
            total++;
            if (obs_l !== exp_vec(1'b1)) begin bad++; $display("FAIL lsb_lsbdut c=%0d got=%b exp=%b", c, obs_l, exp_vec(1'b1)); end
            if (en_l && k < 8) begin
                seq_l[k] = d_l; seq_m[k] = d_m; k++;
            end
            tick();
        end
        total++;
        if (seq_l !== 8'h01 || seq_m !== 8'h80) begin
            bad++; $display("FAIL lsb_sequence got=%b/%b exp=00000001/10000000", seq_l, seq_m);
        end
    endtask

    task automatic test_clear_priority();
        bit acc;
        int clr_at, hs_at;
        acc = 1'b0; clr_at = -1; hs_at = -1;
        for (int c = 0; c < 14; c++) begin
            in_valid = !acc; in_data = 8'h5A; clear_req = (c == 0);
            model_eval(); #1;
            total++;
            if (obs_m !== exp_vec(1'b0)) begin bad++; $display("FAIL clrprio_msb c=%0d got=%b exp=%b", c, obs_m, exp_vec(1'b0)); end
            total++;
            if (obs_l !== exp_vec(1'b1)) begin bad++; $display("FAIL clrprio_lsb c=%0d got=%b exp=%b", c, obs_l, exp_vec(1'b1)); end
            if (in_valid && exp_ready && !acc) begin acc = 1'b1; hs_at = c; end
            if (clr_m && clr_at < 0) clr_at = c;
            tick();
        end
        in_valid = 1'b0;
        total++;
        if (clr_at != 1 || hs_at != 2) begin
            bad++; $display("FAIL clrprio_timing clr_at=%0d hs_at=%0d exp=1/2", clr_at, hs_at);
        end
    endtask

    task automatic test_deferred_clear();
        int clr_cnt, clr_at;
        clr_cnt = 0; clr_at = -1;
        for (int c = 0; c < 14; c++) begin
            in_valid = (c == 0); in_data = (c == 0) ? 8'h96 : 8'($urandom); clear_req = (c == 3 || c == 6);
            model_eval(); #1;
            total++;
            if (obs_m !== exp_vec(1'b0)) begin bad++; $display("FAIL defer_msb c=%0d got=%b exp=%b", c, obs_m, exp_vec(1'b0)); end
            total++;
            if (obs_l !== exp_vec(1'b1)) begin bad++; $display("FAIL defer_lsb c=%0d got=%b exp=%b", c, obs_l, exp_vec(1'b1)); end
            if (clr_m) begin clr_cnt++; clr_at = c; end
            tick();
        end
        total++;
        if (clr_cnt != 1 || clr_at != 10) begin
            bad++; $display("FAIL defer_timing clr_cycles=%0d clr_at=%0d exp=1/10", clr_cnt, clr_at);
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            clear_req = ($urandom_range(0, 15) == 0);
            model_eval(); #1;
            total++;
            if (obs_m !== exp_vec(1'b0)) begin bad++; $display("FAIL rand_msb c=%0d got=%b exp=%b", c, obs_m, exp_vec(1'b0)); end
            total++;
            if (obs_l !== exp_vec(1'b1)) begin bad++; $display("FAIL rand_lsb c=%0d got=%b exp=%b", c, obs_l, exp_vec(1'b1)); end
            if (cur.strobe) begin
                total++;
                if (chain_m !== cur.word || chain_l !== cur.word) begin
                    bad++; $display("FAIL rand_chain c=%0d got=%h/%h exp=%h", c, chain_m, chain_l, cur.word);
                end
            end
            total++;
            if ((en_m && (clr_m || stb_m)) || (en_l && (clr_l || stb_l))) begin
                bad++; $display("FAIL rand_exclusive c=%0d got=%b/%b exp=no overlap", c, obs_m, obs_l);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_shift();
        for (int c = 0; c < 4; c++) begin
            in_valid = (c == 0); in_data = 8'hC3; clear_req = (c == 2);
            model_eval(); #1;
            total++;
            if (obs_m !== exp_vec(1'b0)) begin bad++; $display("FAIL midrst_msb c=%0d got=%b exp=%b", c, obs_m, exp_vec(1'b0)); end
            tick();
        end
        in_valid = 1'b0; clear_req = 1'b0;
        total++;
        if (en_m !== 1'b1 || en_l !== 1'b1) begin
            bad++; $display("FAIL midrst_pre got=%b%b exp=11", en_m, en_l);
        end
        reset = 1'b0;
        #1;
        total++;
        if ({en_m, d_m, busy_m, stb_m, en_l, d_l, busy_l, stb_l} !== 8'b0) begin
            bad++; $display("FAIL midrst_drop got=%b exp=0", {en_m, d_m, busy_m, stb_m, en_l, d_l, busy_l, stb_l});
        end
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            model_eval(); #1;
            total++;
            if (obs_m !== exp_vec(1'b0)) begin bad++; $display("FAIL midrst_after_msb c=%0d got=%b exp=%b", c, obs_m, exp_vec(1'b0)); end
            total++;
            if (obs_l !== exp_vec(1'b1)) begin bad++; $display("FAIL midrst_after_lsb c=%0d got=%b exp=%b", c, obs_l, exp_vec(1'b1)); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_lsb_first();
        test_clear_priority();
        test_deferred_clear();
        test_back_to_back();
        test_reset_mid_shift();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
